// File: rtl/grn_ctrl_pkg.sv
// Shared types and default sizing for the network attractor-search controller.
package grn_ctrl_pkg;

    localparam int unsigned N_NODES_DEF   = 8;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned MAX_STEPS_DEF = 1000;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStep,
        StCheck,
        StPStep,
        StPCheck,
        StDone
    } grn_state_e;

endpackage

// File: rtl/grn_ctrl_cnt.sv
// Saturating up-counter with synchronous clear; sticks at LIMIT and flags it.
module grn_ctrl_cnt #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LIMIT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_limit_o
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign at_limit_o = (cnt_q == Limit);

endmodule

// File: rtl/grn_control.sv
// Floyd tortoise/hare controller: drives two node simulations from a seed,
// detects their meeting, then walks the hare once around to measure the cycle.
module grn_control
    import grn_ctrl_pkg::*;
#(
    parameter int unsigned N_NODES   = N_NODES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MAX_STEPS = MAX_STEPS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_NODES-1:0] seed,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor
);

    localparam logic [CNT_W-1:0] MinMeetSteps = CNT_W'(2);

    grn_state_e state_q, state_d;

    logic               reset_nos_q, start_s0_q, start_s1_q, busy_q, done_q, timeout_q;
    logic [N_NODES-1:0] init_q, attr_q;

    logic steps_clr, steps_inc, steps_at_lim;
    logic period_clr, period_inc, period_at_lim;
    logic latch_seed, capture_attr, set_timeout;

    grn_ctrl_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (MAX_STEPS)
    ) u_steps_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (steps_clr),
        .inc_i      (steps_inc),
        .cnt_o      (steps),
        .at_limit_o (steps_at_lim)
    );

    grn_ctrl_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (MAX_STEPS)
    ) u_period_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (period_clr),
        .inc_i      (period_inc),
        .cnt_o      (period),
        .at_limit_o (period_at_lim)
    );

    // Next-state and per-transition side effects; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        steps_clr    = 1'b0;
        steps_inc    = 1'b0;
        period_clr   = 1'b0;
        period_inc   = 1'b0;
        latch_seed   = 1'b0;
        capture_attr = 1'b0;
        set_timeout  = 1'b0;

        if ((state_q != StIdle) && abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StLoad;
                        latch_seed = 1'b1;
                        steps_clr  = 1'b1;
                        period_clr = 1'b1;
                    end
                end
                StLoad: state_d = StStep;
                StStep: begin
                    steps_inc = 1'b1;
                    state_d   = StCheck;
                end
                StCheck: begin
                    // After one step both copies are trivially equal; not a meeting.
                    if ((steps >= MinMeetSteps) && (s0_vec == s1_vec)) begin
                        capture_attr = 1'b1;
                        period_clr   = 1'b1;
                        state_d      = StPStep;
                    end else if (steps_at_lim) begin
                        set_timeout = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StStep;
                    end
                end
                StPStep: begin
                    period_inc = 1'b1;
                    state_d    = StPCheck;
                end
                StPCheck: begin
                    if (s1_vec == attr_q) begin
                        state_d = StDone;
                    end else if (period_at_lim) begin
                        set_timeout = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StPStep;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs; strobes are decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            init_q      <= '0;
            attr_q      <= '0;
        end else begin
            state_q     <= state_d;
            reset_nos_q <= (state_d == StLoad);
            start_s0_q  <= (state_d == StStep);
            start_s1_q  <= (state_d == StStep) || (state_d == StPStep);
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
            if (latch_seed) begin
                init_q    <= seed;
                timeout_q <= 1'b0;
            end else if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (capture_attr) begin
                attr_q <= s0_vec;
            end
        end
    end

    assign reset_nos  = reset_nos_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign init_state = init_q;
    assign attractor  = attr_q;

endmodule
